// File: rtl/if_id_stall_ctrl.sv
// Front-end stall control for the 5-stage MIPS pipeline.
// Owns the PC and IF/ID register, sequences branch resolution, counts stalls.
module if_id_stall_ctrl #(
  parameter int unsigned       WIDTH    = 32,
  parameter int unsigned       CTRL_W   = 9,
  parameter logic [WIDTH-1:0]  RESET_PC = 32'h0000_0000,
  parameter logic [WIDTH-1:0]  NOP      = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_pc,
  input  logic              stall_control,
  input  logic              branch,
  input  logic              branch_taken,
  input  logic [WIDTH-1:0]  branch_target,
  input  logic              jump,
  input  logic [WIDTH-1:0]  jump_target,
  input  logic [WIDTH-1:0]  instr_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [WIDTH-1:0]  pc_out,
  output logic [WIDTH-1:0]  if_id_instr,
  output logic [WIDTH-1:0]  if_id_pc4,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic              branch_b,
  output logic [15:0]       stall_count
);

  typedef enum logic {
    RUN    = 1'b0,
    BR_RES = 1'b1
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc4;
  } if_id_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc, pc_nxt;
  if_id_t           if_id, if_id_nxt;
  logic [WIDTH-1:0] pc_plus4;
  logic [15:0]      cnt;

  assign pc_plus4 = pc + WIDTH'(4);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if_id_nxt = if_id;
    unique case (state)
      RUN: begin
        if (jump) begin
          pc_nxt          = jump_target;
          if_id_nxt.instr = NOP;
        end else if (branch) begin
          state_nxt = BR_RES;
        end else if (!stall_pc) begin
          pc_nxt          = pc_plus4;
          if_id_nxt.instr = instr_in;
          if_id_nxt.pc4   = pc_plus4;
        end
      end
      BR_RES: begin
        // the held fetch at pc is the fall-through, so not-taken just advances
        state_nxt = RUN;
        if (branch_taken) begin
          pc_nxt          = branch_target;
          if_id_nxt.instr = NOP;
        end else begin
          pc_nxt          = pc_plus4;
          if_id_nxt.instr = instr_in;
          if_id_nxt.pc4   = pc_plus4;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_id.instr <= NOP;
      if_id.pc4   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if_id <= if_id_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (stall_pc && cnt != 16'hFFFF)
      cnt <= cnt + 16'd1;
  end

  assign id_ex_ctrl  = stall_control ? '0 : ctrl_in;
  assign pc_out      = pc;
  assign if_id_instr = if_id.instr;
  assign if_id_pc4   = if_id.pc4;
  assign branch_b    = (state == BR_RES);
  assign stall_count = cnt;

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Directed bench for if_id_stall_ctrl.
// Linear steps with hand-computed expectations.
module tb_if_id_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_pc;
  logic        stall_control;
  logic        branch;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] instr_in;
  logic [8:0]  ctrl_in;
  logic [31:0] pc_out;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [8:0]  id_ex_ctrl;
  logic        branch_b;
  logic [15:0] stall_count;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] IA = 32'h1111_0001;
  localparam logic [31:0] IB = 32'h2222_0002;
  localparam logic [31:0] IC = 32'h3333_0003;
  localparam logic [31:0] ID = 32'h4444_0004;
  localparam logic [31:0] IE = 32'h5555_0005;
  localparam logic [31:0] IF = 32'h6666_0006;
  localparam logic [31:0] IG = 32'h7777_0007;

  if_id_stall_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall_pc      (stall_pc),
    .stall_control (stall_control),
    .branch        (branch),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .instr_in      (instr_in),
    .ctrl_in       (ctrl_in),
    .pc_out        (pc_out),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .id_ex_ctrl    (id_ex_ctrl),
    .branch_b      (branch_b),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall_pc      = 1'b0;
    stall_control = 1'b0;
    branch        = 1'b0;
    branch_taken  = 1'b0;
    jump          = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    idle();
    branch_target = '0;
    jump_target   = '0;
    instr_in      = '0;
    ctrl_in       = 9'h0A5;
    step();
    step();
    rst = 1'b0;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4", if_id_pc4, 32'h0);
    chk("rst_bb", {31'b0, branch_b}, 32'h0);
    chk("rst_cnt", {16'b0, stall_count}, 32'h0);
    #1 chk("ctrl_pass", {23'b0, id_ex_ctrl}, 32'h0A5);

    instr_in = IA;
    step();
    chk("adv1_pc", pc_out, 32'h4);
    chk("adv1_instr", if_id_instr, IA);
    chk("adv1_pc4", if_id_pc4, 32'h4);
    instr_in = IB;
    step();
    chk("adv2_pc", pc_out, 32'h8);
    chk("adv2_instr", if_id_instr, IB);

    // load-use at pc 8
    stall_pc      = 1'b1;
    stall_control = 1'b1;
    ctrl_in       = 9'h1FF;
    instr_in      = IC;
    #1 chk("lu_ctrl0", {23'b0, id_ex_ctrl}, 32'h0);
    step();
    chk("lu_pc", pc_out, 32'h8);
    chk("lu_instr", if_id_instr, IB);
    chk("lu_cnt", {16'b0, stall_count}, 32'h1);
    idle();
    #1 chk("lu_ctrl_back", {23'b0, id_ex_ctrl}, 32'h1FF);
    step();
    chk("adv3_pc", pc_out, 32'hC);
    chk("adv3_instr", if_id_instr, IC);
    chk("adv3_bb", {31'b0, branch_b}, 32'h0);
    instr_in = ID;
    step();
    chk("adv4_pc", pc_out, 32'h10);

    // taken branch at 16
    branch   = 1'b1;
    stall_pc = 1'b1;
    step();
    chk("tb_pc_hold", pc_out, 32'h10);
    chk("tb_bb1", {31'b0, branch_b}, 32'h1);
    chk("tb_instr_hold", if_id_instr, ID);
    chk("tb_cnt", {16'b0, stall_count}, 32'h2);
    idle();
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    step();
    chk("tb_pc_tgt", pc_out, 32'h40);
    chk("tb_bb0", {31'b0, branch_b}, 32'h0);
    chk("tb_nop", if_id_instr, 32'h0);

    // jump back to 16
    idle();
    jump        = 1'b1;
    jump_target = 32'h10;
    step();
    chk("j16_pc", pc_out, 32'h10);

    // not-taken branch at 16; stall_pc in BR_RES is ignored but counted
    idle();
    branch   = 1'b1;
    stall_pc = 1'b1;
    step();
    chk("nt_pc_hold", pc_out, 32'h10);
    chk("nt_bb1", {31'b0, branch_b}, 32'h1);
    idle();
    stall_pc     = 1'b1;
    branch_taken = 1'b0;
    instr_in     = IE;
    step();
    chk("nt_pc", pc_out, 32'h14);
    chk("nt_instr", if_id_instr, IE);
    chk("nt_pc4", if_id_pc4, 32'h14);
    chk("nt_bb0", {31'b0, branch_b}, 32'h0);
    chk("nt_cnt", {16'b0, stall_count}, 32'h4);
    idle();
    instr_in = IF;
    step();
    chk("adv5_pc", pc_out, 32'h18);

    // jump at 24 with bubble and stall_pc (ignored for PC)
    jump          = 1'b1;
    jump_target   = 32'h100;
    stall_control = 1'b1;
    stall_pc      = 1'b1;
    ctrl_in       = 9'h1FF;
    #1 chk("j_ctrl0", {23'b0, id_ex_ctrl}, 32'h0);
    step();
    chk("j_pc", pc_out, 32'h100);
    chk("j_nop", if_id_instr, 32'h0);
    chk("j_cnt", {16'b0, stall_count}, 32'h5);

    // branch and jump together: jump wins
    idle();
    jump        = 1'b1;
    branch      = 1'b1;
    jump_target = 32'h200;
    step();
    chk("bj_pc", pc_out, 32'h200);
    chk("bj_bb", {31'b0, branch_b}, 32'h0);

    // reset during BR_RES
    idle();
    branch = 1'b1;
    step();
    chk("rb_bb1", {31'b0, branch_b}, 32'h1);
    idle();
    rst           = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h80;
    stall_pc      = 1'b1;
    instr_in      = IG;
    step();
    chk("rb_bb0", {31'b0, branch_b}, 32'h0);
    chk("rb_pc", pc_out, 32'h0);
    chk("rb_cnt", {16'b0, stall_count}, 32'h0);
    chk("rb_instr", if_id_instr, 32'h0);
    chk("rb_pc4", if_id_pc4, 32'h0);
    rst = 1'b0;
    idle();

    // PC wrap
    jump        = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    step();
    chk("w_pc_top", pc_out, 32'hFFFF_FFFC);
    idle();
    instr_in = IG;
    step();
    chk("w_pc", pc_out, 32'h0);
    chk("w_pc4", if_id_pc4, 32'h0);
    chk("w_instr", if_id_instr, IG);

    // stall counter saturation
    stall_pc = 1'b1;
    repeat (65534) step();
    chk("sat_fffe", {16'b0, stall_count}, 32'hFFFE);
    chk("sat_pc_hold", pc_out, 32'h0);
    step();
    chk("sat_ffff", {16'b0, stall_count}, 32'hFFFF);
    repeat (3) step();
    chk("sat_hold", {16'b0, stall_count}, 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
